// File: rtl/gate_reduce_pipe.sv
// rtl/gate_reduce_pipe.sv - pipelined multi-lane AND/OR/XOR(+inverted) gate with beat folding and registered output
module gate_reduce_pipe #(
  parameter int IN_NUM = 8,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_NUM*WIDTH-1:0] din,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic [CNT_W-1:0]        beats,
  output logic                    mode_err
);

  localparam logic [1:0]       OP_AND  = 2'd0;
  localparam logic [1:0]       OP_OR   = 2'd1;
  localparam logic [1:0]       OP_XOR  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               mode_err_q, mode_err_d;

  logic [2:0]         grp_mode;
  logic [1:0]         base_op;
  logic               invert;
  logic               reserved;
  logic [WIDTH-1:0]   beat_r;
  logic [WIDTH-1:0]   folded;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      OP_OR:   apply_op = a | b;
      OP_XOR:  apply_op = a ^ b;
      default: apply_op = a & b;
    endcase
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // The group's mode is the live input on its first beat, the latched copy afterwards.
  always_comb begin
    grp_mode = (state_q == IDLE) ? mode : mode_q;
    case (grp_mode)
      3'd1, 3'd4: base_op = OP_OR;
      3'd2, 3'd5: base_op = OP_XOR;
      default:    base_op = OP_AND;
    endcase
    invert   = (grp_mode == 3'd3) || (grp_mode == 3'd4) || (grp_mode == 3'd5);
    reserved = grp_mode[2] && grp_mode[1];
    beat_r   = din[WIDTH-1:0];
    for (int k = 1; k < IN_NUM; k++) begin
      beat_r = apply_op(base_op, beat_r, din[k*WIDTH +: WIDTH]);
    end
    folded  = (state_q == ACCUM) ? apply_op(base_op, acc_q, beat_r) : beat_r;
    cnt_inc = (state_q == IDLE) ? CNT_ONE :
              ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = in_last ? IDLE : ACCUM;
  end

  always_comb begin
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    beats_d     = beats_q;
    mode_err_d  = mode_err_q;
    if (accept && !in_last) begin
      acc_d = folded;
      cnt_d = cnt_inc;
      if (state_q == IDLE) mode_d = mode;
    end
    // A closing beat reloads the output even while the old result drains: no bubble.
    if (accept && in_last) begin
      out_valid_d = 1'b1;
      dout_d      = reserved ? '0 : (invert ? ~folded : folded);
      beats_d     = cnt_inc;
      mode_err_d  = reserved;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= 3'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      beats_q     <= '0;
      mode_err_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      beats_q     <= beats_d;
      mode_err_q  <= mode_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign beats     = beats_q;
  assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// tb/tb_gate_reduce_pipe.sv - scoreboard bench for gate_reduce_pipe (IN_NUM=8, WIDTH=4, CNT_W=3)
module tb_gate_reduce_pipe;

  localparam int IN_NUM = 8;
  localparam int WIDTH  = 4;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] b;
    logic             e;
  } exp_t;

  logic                    clk;
  logic                    rst_n;
  logic [2:0]              mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_NUM*WIDTH-1:0] din;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        dout;
  logic [CNT_W-1:0]        beats;
  logic                    mode_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  gate_reduce_pipe #(.IN_NUM(IN_NUM), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .beats(beats), .mode_err(mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: every handshake on the output side pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", int'(dout), int'(e.d));
        check("beats", int'(beats), int'(e.b));
        check("mode_err", int'(mode_err), int'(e.e));
      end
    end
  end

  task automatic send(input logic [2:0] m, input logic [IN_NUM*WIDTH-1:0] d, input logic last);
    logic taken;
    int   n;
    mode     = m;
    din      = d;
    in_last  = last;
    in_valid = 1'b1;
    n        = 0;
    taken    = 1'b0;
    while (!taken && n < 100) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!taken) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] b, input logic e);
    exp_t x;
    x.d = d;
    x.b = b;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    mode      = 3'd0;
    in_valid  = 1'b0;
    din       = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_beats", int'(beats), 0);
    check("rst_mode_err", int'(mode_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    idle(1);

    // NOR per beat, back to back; lane k bit0 mirrors the 8-bit test pattern.
    expect_res(4'hF, 3'd1, 1'b0);
    send(3'd4, 32'h0000_0000, 1'b1);
    check("latency_out_valid", int'(out_valid), 1);
    expect_res(4'hE, 3'd1, 1'b0);
    send(3'd4, 32'h0000_0010, 1'b1);
    expect_res(4'hE, 3'd1, 1'b0);
    send(3'd4, 32'h0000_0011, 1'b1);

    // XOR group of three beats on lane0: 1 ^ 3 ^ 4 = 6.
    send(3'd2, 32'h0000_0001, 1'b0);
    send(3'd2, 32'h0000_0003, 1'b0);
    check("no_out_midgroup", int'(out_valid), 0);
    expect_res(4'h6, 3'd3, 1'b0);
    send(3'd2, 32'h0000_0004, 1'b1);
    idle(2);

    // Backpressure: pending OR result held while a new last beat waits.
    out_ready = 1'b0;
    expect_res(4'h5, 3'd1, 1'b0);
    send(3'd1, 32'h0000_0005, 1'b1);
    mode     = 3'd0;
    din      = 32'hFFFF_FFFF;
    in_last  = 1'b1;
    in_valid = 1'b1;
    expect_res(4'hF, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_dout", int'(dout), 5);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("no_bubble_valid", int'(out_valid), 1);
    check("no_bubble_dout", int'(dout), 15);
    idle(2);

    // Mode switched mid-group is ignored: AND of 7, E, F = 6.
    send(3'd0, 32'hFFFF_FFF7, 1'b0);
    send(3'd1, 32'hFFFF_FFFE, 1'b0);
    expect_res(4'h6, 3'd3, 1'b0);
    send(3'd1, 32'hFFFF_FFFF, 1'b1);
    idle(2);

    // Reset aborts an open group without residue.
    send(3'd2, 32'h0000_0003, 1'b0);
    send(3'd2, 32'h0000_0005, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_beats", int'(beats), 0);
    check("midrst_mode_err", int'(mode_err), 0);
    expect_res(4'h9, 3'd1, 1'b0);
    send(3'd1, 32'h0000_0009, 1'b1);
    idle(2);

    // Reserved mode consumes and counts beats, then a normal group clears mode_err.
    send(3'd7, 32'h1234_5678, 1'b0);
    expect_res(4'h0, 3'd2, 1'b1);
    send(3'd7, 32'hFFFF_FFFF, 1'b1);
    expect_res(4'hF, 3'd1, 1'b0);
    send(3'd0, 32'hFFFF_FFFF, 1'b1);
    idle(2);

    // Nine-beat OR group: count saturates at 7, beat 8 still folds in.
    for (int i = 1; i <= 8; i++) send(3'd1, (i == 8) ? 32'h0000_0008 : 32'h0, 1'b0);
    expect_res(4'h8, 3'd7, 1'b0);
    send(3'd1, 32'h0, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_reduce_pipe.md
# gate_reduce_pipe

Parametrised, pipelined multi-input logic gate: reduces IN_NUM input lanes of WIDTH bits each with a run-time selectable gate function (AND/OR/XOR and their inversions), optionally folding several consecutive beats into one result. Successor to the fixed single-function gate IP; sits between a valid/ready producer and consumer in lab datapaths. Output is registered, with backpressure support.

## Interface
- IN_NUM, 8, number of input lanes (2..32)
- WIDTH, 1, bits per lane; reduction is bitwise per bit position (1..32)
- CNT_W, 8, width of beat counter output
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- mode  in  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- din  in  IN_NUM*WIDTH  lane k = din[k*WIDTH +: WIDTH]
- in_last  in  1  beat closes the current group (tie 1 for per-beat operation)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  WIDTH  gate result
- beats  out  CNT_W  beats folded into dout, saturating at 2^CNT_W-1
- mode_err  out  1  result was produced under a reserved mode

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- Base op: AND for modes 0/3, OR for 1/4, XOR for 2/5. Invert flag set for modes 3/4/5.
- Per beat: r = base-op reduction over all IN_NUM lanes, bitwise.
- FSM states IDLE (no open group) and ACCUM (group open).
  - IDLE, accepted beat, in_last=0: latch mode, acc <= r, cnt <= 1, go ACCUM.
  - IDLE, accepted beat, in_last=1: load output with r (inverted if flag), beats <= 1; stay IDLE.
  - ACCUM, accepted beat, in_last=0: acc <= acc base-op r, cnt <= cnt+1 (saturating).
  - ACCUM, accepted beat, in_last=1: output = (acc base-op r), inverted if flag; beats <= cnt+1 (saturating); go IDLE.
- Mode is sampled on the first beat of a group only; changes mid-group are ignored until the next group.
- Reserved modes (6/7): beats are consumed and counted normally, dout = 0, mode_err = 1 with the result.
- Output register holds dout/beats/mode_err stable while out_valid && !out_ready.
- Non-last beats do not create output but still respect in_ready (no overtaking of a stalled result).

## Timing
- Reset (rst_n low at a rising edge): out_valid=0, dout=0, beats=0, mode_err=0, state=IDLE, acc=0, cnt=0. Any open group is discarded; no partial result is emitted.
- Latency: last beat accepted at edge t produces out_valid=1 after edge t; visible in cycle t+1.
- Throughput: one beat per cycle when out_ready=1 continuously; back-to-back single-beat groups give one result per cycle.
- Simultaneous drain and load (out_valid && out_ready && new last beat accepted): out_valid stays 1, register takes the new result; no bubble.
- out_valid falls only after a cycle with out_ready=1 and no new result loaded.
- Counter saturation: at cnt = 2^CNT_W-1 further beats still fold into acc, count stays saturated.
- in_valid low: no state change; in_last ignored without valid.

## Test plan
- IN_NUM=8, WIDTH=1, mode=4 (NOR), in_last=1, out_ready=1: din=0x00 -> dout=1; din=0x02 -> dout=0; din=0x03 -> dout=0; each with beats=1, one cycle after acceptance.
- WIDTH=4, mode=2 (XOR) group of 3 beats with all lanes 0 except lane0 = 0x1, 0x3, 0x4 (last on third) -> single result dout=0x6, beats=3; no output on beats 1-2.
- Backpressure: out_ready=0 with a pending result -> in_ready=0, dout held for 5 cycles; raise out_ready with a new last beat waiting -> result handed off and new result loaded in the same cycle.
- Mode change mid-group: group starts with mode=0 (AND), mode switched to 1 on beat 2 -> result computed as AND across the whole group.
- Reset mid-group: 2 beats of open group, rst_n low one cycle -> all outputs 0, next single last beat yields beats=1 with no residue from the aborted group.
- Reserved mode=7, 2-beat group -> dout=0, mode_err=1, beats=2; next mode=0 group -> mode_err=0.
